merge_burst_writer: RTL and testbench

Downstream of the merge integration stage. Consumes the merged, packed AXI-Stream output of one merge pass and writes it to memory as contiguous AXI4 write bursts starting at a programmed base address. Buffers beats in an internal FIFO, issues full bursts while the run streams and a partial burst at run end, and tracks outstanding writes. Signals pass completion only after every write response has returned.

---
 rtl/merge_pkg.sv | 22 ++
 rtl/merge_sync_fifo.sv | 56 +++++
 rtl/merge_burst_writer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_merge_burst_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared types for the merge burst writer slice: FSM states, burst command
// record, AXI burst encoding and a saturating counter helper.
package merge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } merge_wr_state_e;

  typedef struct packed {
    logic [7:0] len;
  } merge_burst_cmd_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/merge_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full, empty and count.
// Pushes while full and pops while empty are dropped.
module merge_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap explicitly so DEPTH need not fill PW.
  always_comb begin
    push_ok  = i_push && !o_full;
    pop_ok   = i_pop && !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer/count registers; storage is not reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/merge_burst_writer.sv
// Writes one merge pass (AXI-Stream) to memory as contiguous AXI4 INCR bursts
// from a programmed base. Full bursts go out while the run streams, a partial
// burst at run end; o_done pulses once every B response has returned.
// Optional macro MERGE_WRITER_STATS_EN adds input/AW stall counters.
module merge_burst_writer
  import merge_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned BURST_LEN        = 16,
  parameter int unsigned FIFO_DEPTH       = 32,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [31:0]                   o_beat_count,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
`ifdef MERGE_WRITER_STATS_EN
  ,
  output logic [31:0]                   o_in_stall_cycles,
  output logic [31:0]                   o_aw_stall_cycles
`endif
);

  localparam int unsigned BEAT_BYTES = AXIS_TDATA_WIDTH / 8;
  localparam int unsigned UW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  merge_wr_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]         next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0]         awaddr_q, awaddr_d;
  logic [7:0]                    awlen_q, awlen_d;
  logic                          awvalid_q, awvalid_d;
  logic [UW-1:0]                 uncommitted_q, uncommitted_d;
  logic [OW-1:0]                 outstanding_q, outstanding_d;
  logic [31:0]                   beat_count_q, beat_count_d;
  logic                          bready_q, bready_d;
  logic [8:0]                    w_left_q, w_left_d;
  logic                          wvalid_q, wvalid_d;
  logic                          wlast_q, wlast_d;
  logic [AXIS_TDATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                          start_acc, in_hs, aw_hs, b_hs, w_hs;
  logic                          issue;
  logic [UW-1:0]                 issue_n;
  logic                          d_full, d_empty, d_pop;
  logic [UW-1:0]                 d_count;
  logic [AXIS_TDATA_WIDTH-1:0]   d_head;
  logic                          cmd_pop, cmd_full, cmd_empty;
  logic [OW-1:0]                 cmd_count;
  merge_burst_cmd_t              cmd_in, cmd_head;

`ifdef MERGE_WRITER_STATS_EN
  logic [31:0] in_stall_q, in_stall_d;
  logic [31:0] aw_stall_q, aw_stall_d;
  assign o_in_stall_cycles = in_stall_q;
  assign o_aw_stall_cycles = aw_stall_q;
`endif

  assign s_axis_tready = (state_q == RUN) && !d_full;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign aw_hs         = awvalid_q && m_axi_awready;
  assign b_hs          = m_axi_bvalid && bready_q;
  assign w_hs          = wvalid_q && m_axi_wready;
  assign start_acc     = (state_q == IDLE) && i_start;
  assign cmd_in.len    = awlen_q;

  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);
  assign o_beat_count  = beat_count_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = bready_q;

  merge_sync_fifo #(
    .WIDTH (AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (in_hs),
    .i_data  (s_axis_tdata),
    .i_pop   (d_pop),
    .o_data  (d_head),
    .o_full  (d_full),
    .o_empty (d_empty),
    .o_count (d_count)
  );

  merge_sync_fifo #(
    .WIDTH ($bits(merge_burst_cmd_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (aw_hs),
    .i_data  (cmd_in),
    .i_pop   (cmd_pop),
    .o_data  (cmd_head),
    .o_full  (cmd_full),
    .o_empty (cmd_empty),
    .o_count (cmd_count)
  );

  // W engine: take a length from the command queue, then stream that many FIFO beats.
  always_comb begin
    cmd_pop  = 1'b0;
    d_pop    = 1'b0;
    w_left_d = w_left_q;
    wvalid_d = wvalid_q;
    wlast_d  = wlast_q;
    wdata_d  = wdata_q;
    if (w_hs) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
    if (w_left_q == '0) begin
      if (!cmd_empty) begin
        cmd_pop  = 1'b1;
        w_left_d = {1'b0, cmd_head.len} + 9'd1;
      end
    end else if ((!wvalid_q || m_axi_wready) && !d_empty) begin
      d_pop    = 1'b1;
      wvalid_d = 1'b1;
      wdata_d  = d_head;
      wlast_d  = (w_left_q == 9'd1);
      w_left_d = w_left_q - 9'd1;
    end
  end

  // Control: FSM, burst issue, address/outstanding/beat bookkeeping.
  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awvalid_d     = awvalid_q;
    outstanding_d = outstanding_q;
    beat_count_d  = beat_count_q;
    bready_d      = 1'b1;
    issue         = 1'b0;
    issue_n       = '0;
`ifdef MERGE_WRITER_STATS_EN
    in_stall_d    = in_stall_q;
    aw_stall_d    = aw_stall_q;
`endif

    // Beats are assigned to a burst when AW is raised, so one cannot be claimed twice.
    if (!awvalid_q && (outstanding_q < OW'(MAX_OUTSTANDING)) && !cmd_full) begin
      if (uncommitted_q >= UW'(BURST_LEN)) begin
        issue   = 1'b1;
        issue_n = UW'(BURST_LEN);
      end else if ((state_q == DRAIN) && (uncommitted_q != '0)) begin
        issue   = 1'b1;
        issue_n = uncommitted_q;
      end
    end
    uncommitted_d = uncommitted_q + UW'(in_hs) - (issue ? issue_n : '0);

    if (aw_hs) begin
      awvalid_d   = 1'b0;
      next_addr_d = next_addr_q
                  + ADDR_WIDTH'({1'b0, awlen_q} + 9'd1) * ADDR_WIDTH'(BEAT_BYTES);
    end
    if (issue) begin
      awvalid_d = 1'b1;
      awaddr_d  = next_addr_q;
      awlen_d   = 8'(issue_n - UW'(1));
    end

    if (aw_hs && !b_hs)
      outstanding_d = outstanding_q + OW'(1);
    else if (b_hs && !aw_hs && (outstanding_q != '0))
      outstanding_d = outstanding_q - OW'(1);

    if (in_hs) beat_count_d = sat_inc32(beat_count_q);

`ifdef MERGE_WRITER_STATS_EN
    if ((state_q == RUN) && s_axis_tvalid && !s_axis_tready) in_stall_d = sat_inc32(in_stall_q);
    if (awvalid_q && !m_axi_awready) aw_stall_d = sat_inc32(aw_stall_q);
`endif

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d      = RUN;
          next_addr_d  = i_base_addr;
          beat_count_d = '0;
        end
      end
      RUN: begin
        if (in_hs && s_axis_tlast) state_d = DRAIN;
      end
      // Next-cycle values are used so o_done follows the last B (or last W) by one cycle.
      DRAIN: begin
        if ((uncommitted_d == '0) && (outstanding_d == '0) && !awvalid_d && !aw_hs
            && (w_left_d == '0) && !wvalid_d && (cmd_count == '0) && (d_count == '0))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MERGE_WRITER_STATS_EN
    if (start_acc) begin
      in_stall_d = '0;
      aw_stall_d = '0;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      next_addr_q   <= '0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      uncommitted_q <= '0;
      outstanding_q <= '0;
      beat_count_q  <= '0;
      bready_q      <= 1'b0;
      w_left_q      <= '0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      wdata_q       <= '0;
`ifdef MERGE_WRITER_STATS_EN
      in_stall_q    <= '0;
      aw_stall_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awvalid_q     <= awvalid_d;
      uncommitted_q <= uncommitted_d;
      outstanding_q <= outstanding_d;
      beat_count_q  <= beat_count_d;
      bready_q      <= bready_d;
      w_left_q      <= w_left_d;
      wvalid_q      <= wvalid_d;
      wlast_q       <= wlast_d;
      wdata_q       <= wdata_d;
`ifdef MERGE_WRITER_STATS_EN
      in_stall_q    <= in_stall_d;
      aw_stall_q    <= aw_stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_merge_burst_writer.sv
// Randomized self-checking bench for merge_burst_writer. A memory-side model
// checks every AW against the burst split implied by the beat count and base,
// every W beat against the input order, and AXI hold rules on AW/W.
// Optional macro MERGE_WRITER_STATS_EN enables the stall-counter checks.
module tb_merge_burst_writer;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 64;
  localparam int unsigned BL = 16;
  localparam int unsigned FD = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned BB = DW / 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start;
  logic [AW-1:0] i_base_addr;
  logic          o_busy, o_done;
  logic [31:0]   o_beat_count;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic          m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready;
`ifdef MERGE_WRITER_STATS_EN
  logic [31:0]   o_in_stall_cycles, o_aw_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  merge_burst_writer #(
    .AXIS_TDATA_WIDTH (DW),
    .ADDR_WIDTH       (AW),
    .BURST_LEN        (BL),
    .FIFO_DEPTH       (FD),
    .MAX_OUTSTANDING  (MO)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_base_addr   (i_base_addr),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_beat_count  (o_beat_count),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
`ifdef MERGE_WRITER_STATS_EN
    ,
    .o_in_stall_cycles (o_in_stall_cycles),
    .o_aw_stall_cycles (o_aw_stall_cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [575:0] got, input logic [575:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected beats, expected AW list, memory-side bookkeeping.
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_aw_addr[$];
  logic [7:0]    exp_aw_len[$];
  logic [AW-1:0] wq_addr[$];
  logic [7:0]    wq_len[$];
  logic [AW-1:0] pass_base = '0;
  logic [AW-1:0] cur_addr  = '0;
  logic [7:0]    cur_len   = '0;
  int aw_seen = 0, w_seen = 0, b_seen = 0, done_cnt = 0, b_pending = 0, beat_idx = 0;
  bit b_en = 1, b_rand = 0, w_rand = 0, aw_hold = 0, tv_rand = 0;
  int aw_mode = 0;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory-side ready/response driver, updated just after each rising edge.
  initial begin
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (aw_hold)           m_axi_awready = 1'b0;
      else if (aw_mode == 1) m_axi_awready = ~m_axi_awready;
      else                   m_axi_awready = 1'b1;
      m_axi_wready = w_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      m_axi_bvalid = b_en && (b_pending > 0) && (!b_rand || ($urandom_range(1, 0) == 1));
    end
  end

  // Monitor on the falling edge: handshakes that will complete at the next rising edge.
  initial begin
    logic [72:0]  prev_aw;
    logic [513:0] prev_w;
    bit prev_aw_stall, prev_w_stall;
    int k;
    prev_aw = '0; prev_w = '0; prev_aw_stall = 0; prev_w_stall = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        wq_addr.delete(); wq_len.delete();
        beat_idx = 0; b_pending = 0; b_seen = aw_seen;
        prev_aw_stall = 0; prev_w_stall = 0;
      end else begin
        if (prev_aw_stall) check_val("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, prev_aw);
        if (prev_w_stall)  check_val("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wlast}, prev_w);
        if (m_axi_awvalid && m_axi_awready) begin
          check_val("aw_outstanding_le_max", (aw_seen - b_seen) < MO, 1);
          if (exp_aw_addr.size() == 0) check_val("aw_extra", m_axi_awaddr, '1);
          else begin
            check_val("awaddr", m_axi_awaddr, exp_aw_addr.pop_front());
            check_val("awlen", m_axi_awlen, exp_aw_len.pop_front());
          end
          wq_addr.push_back(m_axi_awaddr);
          wq_len.push_back(m_axi_awlen);
          aw_seen++;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (beat_idx == 0) begin
            if (wq_addr.size() == 0) check_val("w_before_aw", 0, 1);
            else begin
              cur_addr = wq_addr.pop_front();
              cur_len  = wq_len.pop_front();
            end
          end
          k = int'((cur_addr - pass_base) / BB) + beat_idx;
          if (k < exp_data.size()) check_val("wdata_order", m_axi_wdata, exp_data[k]);
          else check_val("w_extra", k, exp_data.size());
          check_val("wlast", m_axi_wlast, beat_idx == int'(cur_len));
          if (m_axi_wlast) begin b_pending++; beat_idx = 0; end
          else beat_idx++;
          w_seen++;
        end
        if (m_axi_bvalid && m_axi_bready) begin b_pending--; b_seen++; end
        if (o_done) done_cnt++;
      end
      prev_aw       = {m_axi_awvalid, m_axi_awaddr, m_axi_awlen};
      prev_w        = {m_axi_wvalid, m_axi_wdata, m_axi_wlast};
      prev_aw_stall = !i_rst && m_axi_awvalid && !m_axi_awready;
      prev_w_stall  = !i_rst && m_axi_wvalid && !m_axi_wready;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Builds expected data and the burst split (full bursts, then the remainder), then pulses start.
  task automatic start_pass(input logic [AW-1:0] base, input int n);
    exp_data.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    for (int i = 0; i < n; i++) exp_data.push_back(rand_beat());
    for (int off = 0; off < n; off += BL) begin
      exp_aw_addr.push_back(base + AW'(off * BB));
      exp_aw_len.push_back(8'(((n - off) < BL ? (n - off) : BL) - 1));
    end
    pass_base   = base;
    i_start     = 1'b1;
    i_base_addr = base;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int stop_at);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < stop_at && guard < 3000) begin
      if (!s_axis_tvalid && (!tv_rand || $urandom_range(3, 0) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = exp_data[i];
        s_axis_tlast  = (i == n - 1);
      end
      @(negedge i_clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge i_clk); #1;
      if (acc) begin
        i++;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      guard++;
    end
    if (guard >= 3000) check_val("send_timeout", i, stop_at);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    int g = 0;
    do begin
      @(negedge i_clk);
      g++;
    end while (!o_done && g < 5000);
    if (!o_done) check_val("done_timeout", 0, 1);
    if (poke) begin
      i_start = 1'b1;
      i_base_addr = 64'h9000;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      check_val("start_at_done_ignored", o_busy, 0);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic check_pass(input int n, input int d0, input int w0);
    repeat (3) @(posedge i_clk);
    #1;
    check_val("done_once", done_cnt - d0, 1);
    check_val("beat_count", o_beat_count, n);
    check_val("aw_missing", exp_aw_addr.size(), 0);
    check_val("w_beats", w_seen - w0, n);
    check_val("b_all_returned", b_pending, 0);
    check_val("idle_after_done", {o_busy, s_axis_tready, m_axi_awvalid, m_axi_wvalid}, 0);
  endtask

  task automatic run_pass(input logic [AW-1:0] base, input int n, input bit poke, input bit mid);
    int d0 = done_cnt;
    int w0 = w_seen;
    start_pass(base, n);
    fork
      send_beats(n, n);
      begin
        if (mid) begin
          repeat (8) @(posedge i_clk);
          #2;
          i_start = 1'b1;
          i_base_addr = 64'hF000;
          @(posedge i_clk); #2;
          i_start = 1'b0;
        end
      end
    join
    wait_done(poke);
    check_pass(n, d0, w0);
  endtask

  initial begin
    int d0, w0, aw0, g;
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_val("reset_outputs", {o_busy, o_done, s_axis_tready, m_axi_awvalid, m_axi_wvalid,
                                m_axi_wlast, m_axi_bready, o_beat_count}, 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check_val("bready_after_reset", m_axi_bready, 1);

    // Two full bursts, then a start pulse in the o_done cycle.
    run_pass(64'h1000, 32, 1, 0);
    // Two full bursts plus a 5-beat tail.
    run_pass(64'h0, 37, 0, 0);

    // B withheld: outstanding limit caps AWs at 4 and the FIFO fills.
    b_en = 0;
    d0 = done_cnt; w0 = w_seen; aw0 = aw_seen;
    start_pass(64'h4000, 100);
    fork
      send_beats(100, 100);
      begin
        repeat (300) @(negedge i_clk);
        check_val("aw_capped", aw_seen - aw0, MO);
        check_val("beats_when_full", o_beat_count, MO * BL + FD);
        check_val("tready_low_full", s_axis_tready, 0);
        check_val("no_aw_over_limit", m_axi_awvalid, 0);
        @(posedge i_clk); #1;
        b_en = 1;
      end
    join
    wait_done(0);
    check_pass(100, d0, w0);

    // Toggling awready, random wready/bvalid/tvalid, random lengths and bases.
    aw_mode = 1; w_rand = 1; b_rand = 1; tv_rand = 1;
    run_pass(64'h2000, 60, 0, 1);
    for (int p = 0; p < 4; p++)
      run_pass(AW'($urandom_range(63, 0)) * AW'(BL * BB), int'($urandom_range(80, 1)), 0, 0);
    aw_mode = 0; w_rand = 0; b_rand = 0; tv_rand = 0;

    // Reset after 10 beats, then a fresh pass.
    start_pass(64'h3000, 20);
    send_beats(20, 10);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_val("midpass_reset_outputs", {o_busy, o_done, s_axis_tready, m_axi_awvalid, m_axi_wvalid,
                                        m_axi_wlast, m_axi_bready, o_beat_count}, 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    run_pass(64'h3000, 25, 0, 0);

`ifdef MERGE_WRITER_STATS_EN
    aw_hold = 1;
    d0 = done_cnt; w0 = w_seen;
    start_pass(64'h8000, 16);
    send_beats(16, 16);
    g = 0;
    do begin
      @(negedge i_clk);
      g++;
    end while (!m_axi_awvalid && g < 100);
    check_val("stats_awvalid_seen", m_axi_awvalid, 1);
    repeat (20) @(posedge i_clk);
    aw_hold = 0;
    #1;
    check_val("aw_stall_cycles", o_aw_stall_cycles, 20);
    wait_done(0);
    check_pass(16, d0, w0);
    check_val("aw_stall_final", o_aw_stall_cycles, 20);
    check_val("in_stall_none", o_in_stall_cycles, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
